// File: rtl/fnmadd_issue_ctrl.sv
// rtl/fnmadd_issue_ctrl.sv - FNMADD issue/retire controller with credit-checked result FIFO
module fnmadd_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_c,
  input  logic [1:0]           in_rnd,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [WIDTH-1:0]     fma_a,
  output logic [WIDTH-1:0]     fma_b,
  output logic [WIDTH-1:0]     fma_c,
  output logic [1:0]           fma_rnd,
  output logic                 fma_enable,
  input  logic [WIDTH-1:0]     fma_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_is_nan,
  output logic                 out_is_inf,
  output logic                 out_is_zero,
  output logic [15:0]          retired
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FRAC_W = 23;
  localparam int ENT_W  = WIDTH + TAG_WIDTH + 3;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d;
  logic [WIDTH-1:0]     s1_b_q, s1_b_d;
  logic [WIDTH-1:0]     s1_c_q, s1_c_d;
  logic [1:0]           s1_rnd_q, s1_rnd_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [ENT_W-1:0]     mem_d [DEPTH];
  logic [15:0]          retired_q, retired_d;

  logic [AW:0]   count;
  logic [AW+1:0] occupancy;
  logic          accept;
  logic          pop;
  logic          fifo_wr;
  logic          exp_ones;
  logic          exp_zero;
  logic          frac_zero;
  logic [2:0]    wr_flags;
  logic [ENT_W-1:0] head;

  assign count     = wr_ptr_q - rd_ptr_q;
  // Credits cover everything that may still land in the FIFO; a same-cycle pop is not counted.
  assign occupancy = (AW+2)'(count) + (AW+2)'(s1_valid_q) + (AW+2)'(s2_valid_q);
  assign in_ready  = RST & ~flush & (occupancy < (AW+2)'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~flush;
  assign fifo_wr   = s2_valid_q & ~flush;

  assign exp_ones  = &fma_result[WIDTH-2:FRAC_W];
  assign exp_zero  = ~|fma_result[WIDTH-2:FRAC_W];
  assign frac_zero = ~|fma_result[FRAC_W-1:0];
  assign wr_flags  = {exp_ones & ~frac_zero, exp_ones & frac_zero, exp_zero & frac_zero};

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_rnd_d   = s1_rnd_q;
    s1_tag_d   = s1_tag_q;
    if (accept) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_c_d   = in_c;
      s1_rnd_d = in_rnd;
      s1_tag_d = in_tag;
    end

    s2_valid_d = s1_valid_q & ~flush;
    s2_tag_d   = s1_tag_q;

    mem_d = mem_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = {fma_result, s2_tag_q, wr_flags};
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    retired_d = retired_q + {15'd0, pop};
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_rnd_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '{default: '0};
      retired_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_rnd_q   <= s1_rnd_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      retired_q  <= retired_d;
    end
  end

  assign fma_a      = s1_a_q;
  assign fma_b      = s1_b_q;
  assign fma_c      = s1_c_q;
  assign fma_rnd    = s1_rnd_q;
  assign fma_enable = s1_valid_q;

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign out_data    = head[ENT_W-1 -: WIDTH];
  assign out_tag     = head[TAG_WIDTH+2:3];
  assign out_is_nan  = head[2];
  assign out_is_inf  = head[1];
  assign out_is_zero = head[0];
  assign retired     = retired_q;

endmodule

// File: tb/tb_fnmadd_issue_ctrl.sv
// tb/tb_fnmadd_issue_ctrl.sv - scoreboard bench for fnmadd_issue_ctrl
module tb_fnmadd_issue_ctrl;

  logic        clk = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_c;
  logic [1:0]  in_rnd;
  logic [3:0]  in_tag;
  logic [31:0] fma_a, fma_b, fma_c;
  logic [1:0]  fma_rnd;
  logic        fma_enable;
  logic [31:0] fma_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_is_nan, out_is_inf, out_is_zero;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  fnmadd_issue_ctrl dut (
    .clk(clk), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_rnd(in_rnd), .in_tag(in_tag),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_rnd(fma_rnd),
    .fma_enable(fma_enable), .fma_result(fma_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_is_nan(out_is_nan), .out_is_inf(out_is_inf), .out_is_zero(out_is_zero),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Reference triple gives the true -(1*2)-3; other triples use a cheap mix so swapped operands show up.
  function automatic logic [31:0] model_f(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000) return 32'hC0A00000;
    return a ^ {b[15:0], b[31:16]} ^ ~c;
  endfunction

  function automatic logic [2:0] cls(input logic [31:0] d);
    logic eo, ez, fz;
    eo = &d[30:23];
    ez = ~|d[30:23];
    fz = ~|d[22:0];
    return {eo & ~fz, eo & fz, ez & fz};
  endfunction

  always @(posedge clk) fma_result <= fma_enable ? model_f(fma_a, fma_b, fma_c) : 32'h0;

  always @(negedge clk) begin
    if (!RST) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && !flush) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected: got data %h tag %0d, required no result", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_tag !== e.tag ||
              {out_is_nan, out_is_inf, out_is_zero} !== cls(e.data)) begin
            miscompares++;
            $display("FAIL pop_result: got data %h tag %0d flags %b, required data %h tag %0d flags %b",
                     out_data, out_tag, {out_is_nan, out_is_inf, out_is_zero}, e.data, e.tag, cls(e.data));
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{model_f(in_a, in_b, in_c), in_tag});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [1:0] r, input logic [3:0] t);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    in_rnd = r;
    in_tag = t;
  endtask

  task automatic drain;
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1'b1;
      else tick;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
    end
    tick;
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({in_ready, fma_enable, out_valid, retired} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy %b en %b ov %b ret %0d, required all 0", in_ready, fma_enable, out_valid, retired);
    end
    vectors++;
    if ({fma_a, fma_b, fma_c, fma_rnd, out_data, out_tag, out_is_nan, out_is_inf, out_is_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got a %h b %h c %h rnd %b data %h tag %0d, required 0", fma_a, fma_b, fma_c, fma_rnd, out_data, out_tag);
    end
    tick;
    tick;
    RST = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy %b ov %b, required 1 0", in_ready, out_valid);
    end
    tick;
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    set_op(32'h3F800000, 32'h40000000, 32'h40400000, 2'b01, 4'd5);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b, required 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (fma_enable !== 1'b1 || fma_a !== 32'h3F800000 || fma_b !== 32'h40000000 ||
        fma_c !== 32'h40400000 || fma_rnd !== 2'b01) begin
      miscompares++;
      $display("FAIL single_issue: got en %b a %h b %h c %h rnd %b, required 1 3f800000 40000000 40400000 01",
               fma_enable, fma_a, fma_b, fma_c, fma_rnd);
    end
    tick;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fma_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: got ov %b en %b, required 0 0", out_valid, fma_enable);
    end
    tick;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hC0A00000 || out_tag !== 4'd5 ||
        {out_is_nan, out_is_inf, out_is_zero} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_latency: got ov %b data %h tag %0d flags %b, required 1 c0a00000 5 000",
               out_valid, out_data, out_tag, {out_is_nan, out_is_inf, out_is_zero});
    end
    drain;
  endtask

  task automatic test_flags;
    logic [31:0] held;
    out_ready = 1'b0;
    set_op(32'h7FC00000, 32'h0, 32'hFFFFFFFF, 2'b10, 4'd1);
    @(negedge clk); tick;
    set_op(32'hFF800000, 32'h0, 32'hFFFFFFFF, 2'b10, 4'd2);
    @(negedge clk); tick;
    set_op(32'h80000000, 32'h0, 32'hFFFFFFFF, 2'b10, 4'd3);
    @(negedge clk); tick;
    in_valid = 1'b0;
    tick;
    @(negedge clk);
    held = out_data;
    tick;
    @(negedge clk);
    vectors++;
    if (out_data !== held || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flags_stall_stable: got %h ov %b, required %h 1", out_data, out_valid, held);
    end
    out_ready = 1'b1;
    vectors++;
    if ({out_is_nan, out_is_inf, out_is_zero} !== 3'b100) begin
      miscompares++;
      $display("FAIL flags_nan: got %b, required 100", {out_is_nan, out_is_inf, out_is_zero});
    end
    tick;
    @(negedge clk);
    vectors++;
    if ({out_is_nan, out_is_inf, out_is_zero} !== 3'b010) begin
      miscompares++;
      $display("FAIL flags_inf: got %b, required 010", {out_is_nan, out_is_inf, out_is_zero});
    end
    tick;
    @(negedge clk);
    vectors++;
    if ({out_is_nan, out_is_inf, out_is_zero} !== 3'b001) begin
      miscompares++;
      $display("FAIL flags_zero: got %b, required 001", {out_is_nan, out_is_inf, out_is_zero});
    end
    drain;
  endtask

  task automatic test_backpressure;
    int k;
    bit took;
    logic [15:0] base;
    base = retired;
    out_ready = 1'b0;
    k = 0;
    set_op($urandom, $urandom, $urandom, 2'($urandom), 4'(k));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      took = in_ready;
      tick;
      if (took) begin
        k++;
        if (k < 6) set_op($urandom, $urandom, $urandom, 2'($urandom), 4'(k));
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (k !== 4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d accepted rdy %b, required 4 0", k, in_ready);
    end
    tick;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      @(negedge clk);
      took = in_ready;
      tick;
      if (took) begin
        k++;
        if (k < 6) set_op($urandom, $urandom, $urandom, 2'($urandom), 4'(k));
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    drain;
    vectors++;
    if (k !== 6 || retired !== base + 16'd6) begin
      miscompares++;
      $display("FAIL bp_complete: got %0d accepted retired +%0d, required 6 +6", k, retired - base);
    end
  endtask

  task automatic test_throughput;
    int bad, en_cnt;
    logic [15:0] base;
    base = retired;
    bad = 0;
    en_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_op($urandom, $urandom, $urandom, 2'($urandom), 4'(i));
      @(negedge clk);
      if (!in_ready) bad++;
      if (i > 0 && fma_enable) en_cnt++;
      tick;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (fma_enable) en_cnt++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL tp_ready: got %0d stalled cycles, required 0", bad);
    end
    tick;
    @(negedge clk);
    vectors++;
    if (en_cnt !== 16 || fma_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL tp_enable: got %0d enable cycles (now %b), required 16 (now 0)", en_cnt, fma_enable);
    end
    drain;
    vectors++;
    if (retired - base !== 16'd16) begin
      miscompares++;
      $display("FAIL tp_retired: got +%0d, required +16", retired - base);
    end
  endtask

  task automatic test_flush;
    logic [15:0] rb;
    bit stale;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op($urandom, $urandom, $urandom, 2'($urandom), 4'(i));
      @(negedge clk);
      tick;
    end
    rb = retired;
    flush = 1'b1;
    out_ready = 1'b1;
    set_op($urandom, $urandom, $urandom, 2'b00, 4'd7);
    sb.delete();
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || fma_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_setup: got rdy %b ov %b en %b, required 0 1 1", in_ready, out_valid, fma_enable);
    end
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || retired !== rb || fma_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: got ov %b rdy %b ret %0d en %b, required 0 1 %0d 0", out_valid, in_ready, retired, fma_enable, rb);
    end
    stale = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick;
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stale: got stale result %h, required none", out_data);
    end
    tick;
  endtask

  task automatic test_async_reset;
    logic [31:0] a, b, c;
    out_ready = 1'b0;
    set_op($urandom, $urandom, $urandom, 2'b11, 4'd3);
    @(negedge clk);
    tick;
    in_valid = 1'b0;
    tick;
    #2;
    RST = 1'b0;
    #1;
    vectors++;
    if ({in_ready, fma_enable, out_valid, retired, fma_a, fma_b, fma_c, fma_rnd,
         out_data, out_tag, out_is_nan, out_is_inf, out_is_zero} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got rdy %b en %b ov %b ret %0d a %h data %h, required all 0",
               in_ready, fma_enable, out_valid, retired, fma_a, out_data);
    end
    sb.delete();
    tick;
    RST = 1'b1;
    out_ready = 1'b1;
    a = $urandom;
    b = $urandom;
    c = $urandom;
    set_op(a, b, c, 2'b00, 4'd9);
    @(negedge clk);
    tick;
    in_valid = 1'b0;
    tick;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_early: got ov %b, required 0", out_valid);
    end
    tick;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 4'd9 || out_data !== model_f(a, b, c)) begin
      miscompares++;
      $display("FAIL async_after: got ov %b tag %0d data %h, required 1 9 %h", out_valid, out_tag, out_data, model_f(a, b, c));
    end
    drain;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    in_rnd = '0;
    in_tag = '0;
    test_reset;
    test_single;
    test_flags;
    test_backpressure;
    test_throughput;
    test_flush;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
